// File: rtl/alu_op_sequencer_if.sv
// Request, ALU and result bundle of the ALU operation sequencer.
// The master modport is the sequencer; slave is the requester/ALU/consumer side.
interface alu_op_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [12:0] alu_ctl;
    logic [63:0] alu_result;
    logic        done_valid;
    logic        done_ready;
    logic [31:0] z_lo;
    logic [31:0] z_hi;
    logic        err_op;
    logic        busy;

    modport master (
        input  req_valid, req_op, req_a, req_b, alu_result, done_ready,
        output req_ready, alu_a, alu_b, alu_ctl, done_valid, z_lo, z_hi, err_op, busy
    );

    modport slave (
        output req_valid, req_op, req_a, req_b, alu_result, done_ready,
        input  req_ready, alu_a, alu_b, alu_ctl, done_valid, z_lo, z_hi, err_op, busy
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issues one ALU op at a time: IDLE accepts, EXEC holds one-hot control for the op latency, DONE holds the result.
// Optional feature: define DIV_ZERO_CHK_EN to short-circuit DIV by zero into an error result.
module alu_op_sequencer #(
    parameter int MULDIV_CYCLES = 32,
    parameter int SIMPLE_CYCLES = 1
) (
    input  logic               clock,
    input  logic               clear,
    alu_op_sequencer_if.master bus
);
    localparam int MAX_CYCLES = (MULDIV_CYCLES > SIMPLE_CYCLES) ? MULDIV_CYCLES : SIMPLE_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [3:0] OP_MUL  = 4'd6;
    localparam logic [3:0] OP_DIV  = 4'd7;
    localparam logic [3:0] OP_LAST = 4'd12;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t            state_reg, state_next;
    logic [3:0]        op_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [31:0]       alu_a_reg, alu_b_reg;
    logic [31:0]       z_hi_reg, z_lo_reg;
    logic              err_reg;
    logic [12:0]       ctl_onehot;
    logic              accept, illegal_op, div_zero, exec_last, is_muldiv;

    assign accept     = (state_reg == IDLE) && bus.req_valid;
    assign illegal_op = bus.req_op > OP_LAST;
    assign is_muldiv  = (bus.req_op == OP_MUL) || (bus.req_op == OP_DIV);
    assign exec_last  = (cnt_reg == '0);

`ifdef DIV_ZERO_CHK_EN
    assign div_zero = (bus.req_op == OP_DIV) && (bus.req_b == 32'd0);
`else
    assign div_zero = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (clear) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.req_valid) begin
                    // Ops with no ALU work skip EXEC and present their result next cycle
                    state_next = (illegal_op || div_zero) ? DONE : EXEC;
                end
            end
            EXEC: begin
                if (exec_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.done_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            op_reg    <= '0;
            cnt_reg   <= '0;
            alu_a_reg <= '0;
            alu_b_reg <= '0;
            z_hi_reg  <= '0;
            z_lo_reg  <= '0;
            err_reg   <= 1'b0;
        end else if (accept) begin
            alu_a_reg <= bus.req_a;
            alu_b_reg <= bus.req_b;
            op_reg    <= bus.req_op;
            cnt_reg   <= is_muldiv ? CNT_W'(MULDIV_CYCLES - 1) : CNT_W'(SIMPLE_CYCLES - 1);
            if (illegal_op) begin
                z_hi_reg <= '0;
                z_lo_reg <= '0;
                err_reg  <= 1'b1;
            end else if (div_zero) begin
                z_hi_reg <= bus.req_a;
                z_lo_reg <= 32'hFFFF_FFFF;
                err_reg  <= 1'b1;
            end
        end else if (state_reg == EXEC) begin
            if (exec_last) begin
                z_hi_reg <= bus.alu_result[63:32];
                z_lo_reg <= bus.alu_result[31:0];
                err_reg  <= 1'b0;
            end else begin
                cnt_reg <= cnt_reg - 1'b1;
            end
        end
    end

    // Illegal opcodes never reach EXEC, so a plain decode of op_reg is one-hot
    generate
        for (genvar gi = 0; gi < 13; gi++) begin : g_ctl
            assign ctl_onehot[gi] = (state_reg == EXEC) && (op_reg == 4'(gi));
        end
    endgenerate

    assign bus.req_ready  = (state_reg == IDLE);
    assign bus.busy       = (state_reg != IDLE);
    assign bus.done_valid = (state_reg == DONE);
    assign bus.alu_ctl    = ctl_onehot;
    assign bus.alu_a      = alu_a_reg;
    assign bus.alu_b      = alu_b_reg;
    assign bus.z_hi       = z_hi_reg;
    assign bus.z_lo       = z_lo_reg;
    assign bus.err_op     = err_reg;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: a small ALU answers the one-hot control, each step checked by assertion.
module tb_alu_op_sequencer;
    logic clock = 1'b0;
    logic clear = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_op_sequencer_if io ();

    alu_op_sequencer #(
        .MULDIV_CYCLES(32),
        .SIMPLE_CYCLES(1)
    ) dut (
        .clock(clock),
        .clear(clear),
        .bus  (io)
    );

    always #5 clock = ~clock;

    // Minimal ALU for the ops exercised; a recognisable junk value otherwise
    always_comb begin
        io.alu_result = 64'hBAD0_BAD0_BAD0_BAD0;
        case (io.alu_ctl)
            13'h0001: io.alu_result = {32'd0, io.alu_a & io.alu_b};
            13'h0002: io.alu_result = {32'd0, io.alu_a | io.alu_b};
            13'h0010: io.alu_result = {32'd0, io.alu_a + io.alu_b};
            13'h0040: io.alu_result = 64'(io.alu_a) * 64'(io.alu_b);
            13'h0080: io.alu_result = (io.alu_b == 32'd0) ? {io.alu_a, 32'hFFFF_FFFF}
                                                          : {io.alu_a % io.alu_b, io.alu_a / io.alu_b};
            13'h0400: io.alu_result = {32'd0, io.alu_a << io.alu_b[4:0]};
            default:  io.alu_result = 64'hBAD0_BAD0_BAD0_BAD0;
        endcase
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept one request and run until done_valid, recording latency and ALU control activity
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int ctl_cycles, output logic [12:0] ctl_seen);
        io.req_op    = op;
        io.req_a     = a;
        io.req_b     = b;
        io.req_valid = 1'b1;
        step();
        io.req_valid = 1'b0;
        lat        = 1;
        ctl_cycles = 0;
        ctl_seen   = '0;
        while (!io.done_valid && lat < 200) begin
            if (io.alu_ctl != 13'd0) begin
                ctl_cycles++;
                ctl_seen |= io.alu_ctl;
            end
            step();
            lat++;
        end
        $display("op=%0d a=%0h b=%0h latency=%0d ctl_cycles=%0d z_hi=%0h z_lo=%0h err=%0b",
                 op, a, b, lat, ctl_cycles, io.z_hi, io.z_lo, io.err_op);
    endtask

    task automatic ack();
        io.done_ready = 1'b1;
        step();
        io.done_ready = 1'b0;
    endtask

    initial begin
        int          lat;
        int          ctl_cycles;
        logic [12:0] ctl_seen;
        bit          saw_done;

        io.req_valid  = 1'b0;
        io.req_op     = '0;
        io.req_a      = '0;
        io.req_b      = '0;
        io.done_ready = 1'b0;
        repeat (3) step();
        clear = 1'b0;

        // Reset state
        chk("rst_req_ready", io.req_ready, 1);
        chk("rst_busy", io.busy, 0);
        chk("rst_done_valid", io.done_valid, 0);
        chk("rst_alu_ctl", io.alu_ctl, 0);
        chk("rst_alu_a", io.alu_a, 0);
        chk("rst_z", {io.z_hi, io.z_lo}, 0);
        chk("rst_err", io.err_op, 0);

        // ADD 5+7
        run_op(4'd4, 32'd5, 32'd7, lat, ctl_cycles, ctl_seen);
        chk("add_latency", lat, 2);
        chk("add_ctl_cycles", ctl_cycles, 1);
        chk("add_ctl", ctl_seen, 13'h0010);
        chk("add_z_lo", io.z_lo, 12);
        chk("add_z_hi", io.z_hi, 0);
        chk("add_err", io.err_op, 0);
        chk("add_req_ready_done", io.req_ready, 0);
        ack();
        chk("add_done_cleared", io.done_valid, 0);
        chk("add_idle_ready", io.req_ready, 1);

        // DIV 17/5
        run_op(4'd7, 32'd17, 32'd5, lat, ctl_cycles, ctl_seen);
        chk("div_latency", lat, 33);
        chk("div_ctl_cycles", ctl_cycles, 32);
        chk("div_ctl", ctl_seen, 13'h0080);
        chk("div_z_lo", io.z_lo, 3);
        chk("div_z_hi", io.z_hi, 2);
        chk("div_err", io.err_op, 0);
        ack();

        // MUL with a nonzero high word
        run_op(4'd6, 32'h0001_0000, 32'h0001_0000, lat, ctl_cycles, ctl_seen);
        chk("mul_latency", lat, 33);
        chk("mul_ctl", ctl_seen, 13'h0040);
        chk("mul_z", {io.z_hi, io.z_lo}, 64'h1_0000_0000);
        ack();

        // SHL 1<<4 under back-pressure with a competing request
        run_op(4'd10, 32'd1, 32'd4, lat, ctl_cycles, ctl_seen);
        chk("shl_latency", lat, 2);
        io.req_op    = 4'd4;
        io.req_a     = 32'd99;
        io.req_b     = 32'd1;
        io.req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_z_lo", io.z_lo, 16);
            chk("bp_req_ready", io.req_ready, 0);
            chk("bp_done_valid", io.done_valid, 1);
        end
        // done_ready and req_valid together: release only, no accept
        io.done_ready = 1'b1;
        step();
        io.done_ready = 1'b0;
        io.req_valid  = 1'b0;
        chk("sim_idle", io.busy, 0);
        chk("sim_req_ready", io.req_ready, 1);
        chk("sim_alu_a_held", io.alu_a, 1);
        chk("sim_alu_b_held", io.alu_b, 4);

        // Illegal opcode 14 after a result that was nonzero
        run_op(4'd14, 32'h1234, 32'h5678, lat, ctl_cycles, ctl_seen);
        chk("ill_latency", lat, 1);
        chk("ill_ctl_cycles", ctl_cycles, 0);
        chk("ill_err", io.err_op, 1);
        chk("ill_z", {io.z_hi, io.z_lo}, 0);
        chk("ill_alu_ctl", io.alu_ctl, 0);
        ack();

        // clear in the middle of a MUL
        io.req_op    = 4'd6;
        io.req_a     = 32'd6;
        io.req_b     = 32'd7;
        io.req_valid = 1'b1;
        step();
        io.req_valid = 1'b0;
        repeat (5) step();
        chk("mulclr_ctl_mid", io.alu_ctl, 13'h0040);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_req_ready", io.req_ready, 1);
        chk("clr_busy", io.busy, 0);
        chk("clr_alu_ctl", io.alu_ctl, 0);
        chk("clr_alu_a", io.alu_a, 0);
        chk("clr_err", io.err_op, 0);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (io.done_valid) saw_done = 1'b1;
        end
        chk("clr_no_done", saw_done, 0);
        run_op(4'd1, 32'd3, 32'd4, lat, ctl_cycles, ctl_seen);
        chk("or_latency", lat, 2);
        chk("or_ctl", ctl_seen, 13'h0002);
        chk("or_z_lo", io.z_lo, 7);
        chk("or_err", io.err_op, 0);
        ack();

        // DIV by zero
        run_op(4'd7, 32'd9, 32'd0, lat, ctl_cycles, ctl_seen);
`ifdef DIV_ZERO_CHK_EN
        chk("dz_latency", lat, 1);
        chk("dz_ctl_cycles", ctl_cycles, 0);
        chk("dz_err", io.err_op, 1);
`else
        chk("dz_latency", lat, 33);
        chk("dz_ctl_cycles", ctl_cycles, 32);
        chk("dz_err", io.err_op, 0);
`endif
        chk("dz_z_hi", io.z_hi, 9);
        chk("dz_z_lo", io.z_lo, 32'hFFFF_FFFF);
        ack();
        chk("final_idle", io.req_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
